ac_multizone_control: RTL and testbench

//  Per-zone air-conditioning controller for NUM_ZONES independent zones.
//  - Each zone has its own setpoint buttons, mode button and temperature sensor input.
//  - Each zone drives its own fan speed and fan heat outputs.
//  - Successor to the single-zone AC block: adds zone count, a parametrised setpoint range,
//    a soft-start fan ramp and optional button auto-repeat.
//  - Sits between the button/sensor front end and the fan actuator drivers.

---
 rtl/ac_pkg.sv | 36 +++
 rtl/ac_zone_channel.sv | 187 ++++++++++++++++++
 rtl/ac_multizone_control.sv | 49 ++++
 tb/tb_ac_multizone_control.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ac_pkg.sv
// rtl/ac_pkg.sv - shared mode, speed and AUTO-table constants for the multizone AC controller
package ac_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_AUTO = 2'b01,
        MODE_FAST = 2'b10,
        MODE_ECO  = 2'b11
    } mode_e;

    localparam logic [2:0] SPEED_OFF  = 3'd0;
    localparam logic [2:0] SPEED_LOW  = 3'd1;
    localparam logic [2:0] SPEED_MID  = 3'd2;
    localparam logic [2:0] SPEED_HIGH = 3'd3;
    localparam logic [2:0] SPEED_MAX  = 3'd4;

    // AUTO mode: upper diff bound of each band (inclusive)
    localparam int AUTO_DIFF_IDLE = 2;
    localparam int AUTO_DIFF_LOW  = 4;
    localparam int AUTO_DIFF_MID  = 6;
    localparam int AUTO_DIFF_HIGH = 8;

    // Outlet target is setpoint minus one of these offsets
    localparam int HEAT_OFS_LOW  = 1;
    localparam int HEAT_OFS_MID  = 3;
    localparam int HEAT_OFS_HIGH = 5;
    localparam int HEAT_OFS_ECO  = 2;

    // Setpoint minus offset, clamped at zero
    function automatic logic [7:0] heat_minus(input logic [7:0] sp, input int ofs);
        logic [7:0] o;
        o = 8'(ofs);
        return (sp > o) ? (sp - o) : 8'd0;
    endfunction

endpackage

// File: rtl/ac_zone_channel.sv
// rtl/ac_zone_channel.sv - one AC zone: button edges, setpoint, mode FSM, diff, target, fan ramp (AC_AUTOREPEAT_EN adds held-button repeat)
module ac_zone_channel
    import ac_pkg::*;
#(
    parameter int TEMP_W        = 7,
    parameter int MIN_TEMP      = 18,
    parameter int MAX_TEMP      = 26,
    parameter int RAMP_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 50
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              button_up,
    input  logic              button_down,
    input  logic              button_ac,
    input  logic [TEMP_W-1:0] temperature,
    output logic [TEMP_W-1:0] setpoint,
    output logic [1:0]        mode,
    output logic [2:0]        fan_speed,
    output logic [7:0]        fan_heat
);

    localparam int RAMP_W = $clog2(RAMP_CYCLES + 1);

    if (RAMP_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cycles
        $error("ac_zone_channel: RAMP_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    logic              up_prev_q, down_prev_q, ac_prev_q;
    logic [TEMP_W-1:0] setpoint_q, setpoint_d;
    mode_e             mode_q, mode_d;
    logic [TEMP_W-1:0] diff_q, diff_d;
    logic [2:0]        tgt_speed_q, tgt_speed_d;
    logic [7:0]        fan_heat_q, fan_heat_d;
    logic [2:0]        fan_speed_q, fan_speed_d;
    logic [RAMP_W-1:0] ramp_cnt_q, ramp_cnt_d;

    logic up_press, down_press, ac_press;
    logic up_step, down_step;

    assign up_press   = button_up & ~up_prev_q;
    assign down_press = button_down & ~down_prev_q;
    assign ac_press   = button_ac & ~ac_prev_q;

`ifdef AC_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

    logic             rep_hold, rep_fire;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

    // Exactly one setpoint button held: count the hold and fire a step every REPEAT_CYCLES
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_fire  = 1'b0;
        rep_hold  = button_up ^ button_down;
        if (!rep_hold || up_press || down_press) begin
            rep_cnt_d = '0;
        end else if (rep_cnt_q == REP_W'(REPEAT_CYCLES - 1)) begin
            rep_cnt_d = '0;
            rep_fire  = 1'b1;
        end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
    end

    // Repeat counter; cleared by reset and whenever the hold is broken
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end

    assign up_step   = up_press | (rep_fire & button_up);
    assign down_step = down_press | (rep_fire & button_down);
`else
    assign up_step   = up_press;
    assign down_step = down_press;
`endif

    // Setpoint saturating step and mode cycle OFF->AUTO->FAST->ECO->OFF
    always_comb begin
        setpoint_d = setpoint_q;
        if (up_step && !down_step && setpoint_q < TEMP_W'(MAX_TEMP)) begin
            setpoint_d = setpoint_q + TEMP_W'(1);
        end else if (down_step && !up_step && setpoint_q > TEMP_W'(MIN_TEMP)) begin
            setpoint_d = setpoint_q - TEMP_W'(1);
        end
        mode_d = mode_q;
        if (ac_press) begin
            case (mode_q)
                MODE_OFF:  mode_d = MODE_AUTO;
                MODE_AUTO: mode_d = MODE_FAST;
                MODE_FAST: mode_d = MODE_ECO;
                MODE_ECO:  mode_d = MODE_OFF;
                default:   mode_d = MODE_OFF;
            endcase
        end
    end

    // Absolute error against the setpoint, then the per-mode speed/heat target from last cycle's error
    always_comb begin
        diff_d      = (temperature >= setpoint_q) ? (temperature - setpoint_q)
                                                  : (setpoint_q - temperature);
        tgt_speed_d = SPEED_OFF;
        fan_heat_d  = 8'd0;
        case (mode_q)
            MODE_AUTO: begin
                if (diff_q <= TEMP_W'(AUTO_DIFF_IDLE)) begin
                    tgt_speed_d = SPEED_OFF;
                end else if (diff_q <= TEMP_W'(AUTO_DIFF_LOW)) begin
                    tgt_speed_d = SPEED_LOW;
                    fan_heat_d  = heat_minus(8'(setpoint_q), HEAT_OFS_LOW);
                end else if (diff_q <= TEMP_W'(AUTO_DIFF_MID)) begin
                    tgt_speed_d = SPEED_MID;
                    fan_heat_d  = heat_minus(8'(setpoint_q), HEAT_OFS_MID);
                end else begin
                    tgt_speed_d = (diff_q <= TEMP_W'(AUTO_DIFF_HIGH)) ? SPEED_HIGH : SPEED_MAX;
                    fan_heat_d  = heat_minus(8'(setpoint_q), HEAT_OFS_HIGH);
                end
            end
            MODE_FAST: begin
                tgt_speed_d = SPEED_MAX;
                fan_heat_d  = heat_minus(8'(setpoint_q), HEAT_OFS_HIGH);
            end
            MODE_ECO: begin
                tgt_speed_d = SPEED_MID;
                fan_heat_d  = heat_minus(8'(setpoint_q), HEAT_OFS_ECO);
            end
            default: begin
                tgt_speed_d = SPEED_OFF;
                fan_heat_d  = 8'd0;
            end
        endcase
    end

    // Soft-start: one speed step per RAMP_CYCLES toward target; OFF drops the fan immediately
    always_comb begin
        fan_speed_d = fan_speed_q;
        ramp_cnt_d  = ramp_cnt_q;
        if (mode_q == MODE_OFF) begin
            fan_speed_d = SPEED_OFF;
            ramp_cnt_d  = '0;
        end else if (fan_speed_q == tgt_speed_q) begin
            ramp_cnt_d = '0;
        end else if (ramp_cnt_q == RAMP_W'(RAMP_CYCLES - 1)) begin
            ramp_cnt_d  = '0;
            fan_speed_d = (fan_speed_q < tgt_speed_q) ? (fan_speed_q + 3'd1) : (fan_speed_q - 3'd1);
        end else begin
            ramp_cnt_d = ramp_cnt_q + RAMP_W'(1);
        end
    end

    // Zone state registers with asynchronous clear to the power-on state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_prev_q   <= 1'b0;
            down_prev_q <= 1'b0;
            ac_prev_q   <= 1'b0;
            setpoint_q  <= TEMP_W'(MIN_TEMP);
            mode_q      <= MODE_OFF;
            diff_q      <= '0;
            tgt_speed_q <= SPEED_OFF;
            fan_heat_q  <= 8'd0;
            fan_speed_q <= SPEED_OFF;
            ramp_cnt_q  <= '0;
        end else begin
            up_prev_q   <= button_up;
            down_prev_q <= button_down;
            ac_prev_q   <= button_ac;
            setpoint_q  <= setpoint_d;
            mode_q      <= mode_d;
            diff_q      <= diff_d;
            tgt_speed_q <= tgt_speed_d;
            fan_heat_q  <= fan_heat_d;
            fan_speed_q <= fan_speed_d;
            ramp_cnt_q  <= ramp_cnt_d;
        end
    end

    assign setpoint  = setpoint_q;
    assign mode      = mode_q;
    assign fan_speed = fan_speed_q;
    assign fan_heat  = fan_heat_q;

endmodule

// File: rtl/ac_multizone_control.sv
// rtl/ac_multizone_control.sv - NUM_ZONES independent AC zone channels on flat buses (AC_AUTOREPEAT_EN enables button auto-repeat)
module ac_multizone_control
    import ac_pkg::*;
#(
    parameter int NUM_ZONES     = 2,
    parameter int TEMP_W        = 7,
    parameter int MIN_TEMP      = 18,
    parameter int MAX_TEMP      = 26,
    parameter int RAMP_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 50
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_ZONES-1:0]        button_up,
    input  logic [NUM_ZONES-1:0]        button_down,
    input  logic [NUM_ZONES-1:0]        button_ac,
    input  logic [NUM_ZONES*TEMP_W-1:0] temperature,
    output logic [NUM_ZONES*TEMP_W-1:0] temperature_registered,
    output logic [NUM_ZONES*2-1:0]      current_mode,
    output logic [NUM_ZONES*3-1:0]      fan_speed,
    output logic [NUM_ZONES*8-1:0]      fan_heat
);

    if (NUM_ZONES < 1 || NUM_ZONES > 8) begin : g_bad_zones
        $error("ac_multizone_control: NUM_ZONES must be 1..8");
    end

    for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
        ac_zone_channel #(
            .TEMP_W        (TEMP_W),
            .MIN_TEMP      (MIN_TEMP),
            .MAX_TEMP      (MAX_TEMP),
            .RAMP_CYCLES   (RAMP_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_zone (
            .clk         (clk),
            .reset       (reset),
            .button_up   (button_up[z]),
            .button_down (button_down[z]),
            .button_ac   (button_ac[z]),
            .temperature (temperature[z*TEMP_W +: TEMP_W]),
            .setpoint    (temperature_registered[z*TEMP_W +: TEMP_W]),
            .mode        (current_mode[z*2 +: 2]),
            .fan_speed   (fan_speed[z*3 +: 3]),
            .fan_heat    (fan_heat[z*8 +: 8])
        );
    end

endmodule

// File: tb/tb_ac_multizone_control.sv
// tb/tb_ac_multizone_control.sv - scoreboard bench: directed scenarios plus random buttons/temperatures vs a reference model
module tb_ac_multizone_control;

    localparam int NZ   = 2;
    localparam int TW   = 7;
    localparam int MINT = 18;
    localparam int MAXT = 26;
    localparam int RC   = 4;
    localparam int RPC  = 5;
`ifdef AC_AUTOREPEAT_EN
    localparam int HOLD_SP = 22;
`else
    localparam int HOLD_SP = 19;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic [NZ-1:0]       button_up, button_down, button_ac;
    logic [NZ*TW-1:0]    temperature;
    logic [NZ*TW-1:0]    temperature_registered;
    logic [NZ*2-1:0]     current_mode;
    logic [NZ*3-1:0]     fan_speed;
    logic [NZ*8-1:0]     fan_heat;

    ac_multizone_control #(
        .NUM_ZONES(NZ), .TEMP_W(TW), .MIN_TEMP(MINT), .MAX_TEMP(MAXT),
        .RAMP_CYCLES(RC), .REPEAT_CYCLES(RPC)
    ) dut (
        .clk(clk), .reset(reset),
        .button_up(button_up), .button_down(button_down), .button_ac(button_ac),
        .temperature(temperature),
        .temperature_registered(temperature_registered),
        .current_mode(current_mode), .fan_speed(fan_speed), .fan_heat(fan_heat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NZ*TW-1:0] sp;
        logic [NZ*2-1:0]  md;
        logic [NZ*3-1:0]  fs;
        logic [NZ*8-1:0]  fh;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference state: plain integers per zone
    int m_sp[NZ], m_mode[NZ], m_upv[NZ], m_dnv[NZ], m_acv[NZ], m_rep[NZ];
    int m_diff[NZ], m_tspd[NZ], m_heat[NZ], m_spd[NZ], m_rcnt[NZ];

    // Next values to drive, applied at the following falling edge
    logic [NZ-1:0]    nu, nd, na;
    logic [NZ*TW-1:0] nt;
    logic             nrst;

    function automatic void chk(input string name, input int z, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s zone%0d: got %0d expected %0d at %0t", name, z, act, exp, $time);
        end
    endfunction

    function automatic int sat0(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    // Fan target from the mode/diff table: returns speed and heat
    function automatic void target(input int mode, input int sp, input int diff,
                                   output int spd, output int heat);
        int band;
        int ofs_tab[5] = '{0, 1, 3, 5, 5};
        spd = 0; heat = 0;
        if (mode == 1) begin
            band = (diff <= 2) ? 0 : (diff <= 4) ? 1 : (diff <= 6) ? 2 : (diff <= 8) ? 3 : 4;
            spd  = band;
            heat = (band == 0) ? 0 : sat0(sp - ofs_tab[band]);
        end else if (mode == 2) begin
            spd = 4; heat = sat0(sp - 5);
        end else if (mode == 3) begin
            spd = 2; heat = sat0(sp - 2);
        end
    endfunction

    function automatic void model_reset();
        for (int z = 0; z < NZ; z++) begin
            m_sp[z] = MINT; m_mode[z] = 0; m_upv[z] = 0; m_dnv[z] = 0; m_acv[z] = 0;
            m_rep[z] = 0; m_diff[z] = 0; m_tspd[z] = 0; m_heat[z] = 0; m_spd[z] = 0; m_rcnt[z] = 0;
        end
    endfunction

    // Advance the model by one clock using the inputs just applied, then queue the expectation
    function automatic void model_step();
        exp_t e;
        if (!reset) begin
            model_reset();
        end else begin
            for (int z = 0; z < NZ; z++) begin
                int t, upp, dnp, acp, ups, dns, nsp, nmode, ndiff, ntspd, nheat, nspd, nrc;
                t   = int'(temperature[z*TW +: TW]);
                upp = (button_up[z] && m_upv[z] == 0) ? 1 : 0;
                dnp = (button_down[z] && m_dnv[z] == 0) ? 1 : 0;
                acp = (button_ac[z] && m_acv[z] == 0) ? 1 : 0;
                ups = upp; dns = dnp;
`ifdef AC_AUTOREPEAT_EN
                if (button_up[z] != button_down[z] && upp == 0 && dnp == 0) begin
                    if (m_rep[z] == RPC - 1) begin
                        m_rep[z] = 0;
                        if (button_up[z]) ups = 1; else dns = 1;
                    end else begin
                        m_rep[z]++;
                    end
                end else begin
                    m_rep[z] = 0;
                end
`endif
                nsp = m_sp[z];
                if (ups == 1 && dns == 0) nsp = (m_sp[z] + 1 > MAXT) ? MAXT : m_sp[z] + 1;
                if (dns == 1 && ups == 0) nsp = (m_sp[z] - 1 < MINT) ? MINT : m_sp[z] - 1;
                nmode = (acp == 1) ? (m_mode[z] + 1) % 4 : m_mode[z];
                ndiff = (t > m_sp[z]) ? t - m_sp[z] : m_sp[z] - t;
                target(m_mode[z], m_sp[z], m_diff[z], ntspd, nheat);
                nspd = m_spd[z]; nrc = m_rcnt[z];
                if (m_mode[z] == 0) begin
                    nspd = 0; nrc = 0;
                end else if (m_spd[z] == m_tspd[z]) begin
                    nrc = 0;
                end else if (m_rcnt[z] == RC - 1) begin
                    nrc = 0;
                    nspd = m_spd[z] + ((m_tspd[z] > m_spd[z]) ? 1 : -1);
                end else begin
                    nrc = m_rcnt[z] + 1;
                end
                m_upv[z] = int'(button_up[z]); m_dnv[z] = int'(button_down[z]); m_acv[z] = int'(button_ac[z]);
                m_sp[z] = nsp; m_mode[z] = nmode; m_diff[z] = ndiff;
                m_tspd[z] = ntspd; m_heat[z] = nheat; m_spd[z] = nspd; m_rcnt[z] = nrc;
            end
        end
        for (int z = 0; z < NZ; z++) begin
            e.sp[z*TW +: TW] = TW'(m_sp[z]);
            e.md[z*2 +: 2]   = 2'(m_mode[z]);
            e.fs[z*3 +: 3]   = 3'(m_spd[z]);
            e.fh[z*8 +: 8]   = 8'(m_heat[z]);
        end
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(negedge clk);
        reset = nrst; button_up = nu; button_down = nd; button_ac = na; temperature = nt;
        model_step();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic press_ac(input int z);
        na[z] = 1'b1; tick();
        na[z] = 1'b0; tick();
    endtask

    function automatic void chk_reset_state(input string name);
        for (int z = 0; z < NZ; z++) begin
            chk({name, "_sp"}, z, int'(temperature_registered[z*TW +: TW]), MINT);
            chk({name, "_mode"}, z, int'(current_mode[z*2 +: 2]), 0);
            chk({name, "_speed"}, z, int'(fan_speed[z*3 +: 3]), 0);
            chk({name, "_heat"}, z, int'(fan_heat[z*8 +: 8]), 0);
        end
    endfunction

    // Monitor: every clock, pop the expectation queued for this edge and compare all zones
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int z = 0; z < NZ; z++) begin
                    chk("sb_setpoint", z, int'(temperature_registered[z*TW +: TW]), int'(e.sp[z*TW +: TW]));
                    chk("sb_mode", z, int'(current_mode[z*2 +: 2]), int'(e.md[z*2 +: 2]));
                    chk("sb_speed", z, int'(fan_speed[z*3 +: 3]), int'(e.fs[z*3 +: 3]));
                    chk("sb_heat", z, int'(fan_heat[z*8 +: 8]), int'(e.fh[z*8 +: 8]));
                end
            end
        end
    end

    initial begin
        int auto_t[4]  = '{23, 25, 27, 30};
        int auto_h[4]  = '{19, 17, 15, 15};
        int auto_s[4]  = '{1, 2, 3, 4};

        reset = 1'b0; button_up = '0; button_down = '0; button_ac = '0;
        nu = '0; nd = '0; na = '0; nrst = 1'b0;
        nt = {TW'(20), TW'(20)};
        temperature = nt;
        model_reset();

        tick(); #1;
        chk_reset_state("reset_init");
        ticks(2);
        nrst = 1'b1;
        ticks(2);

        // Saturation on zone 0, zone 1 must stay put
        for (int i = 0; i < 10; i++) begin nu[0] = 1'b1; tick(); nu[0] = 1'b0; tick(); end
        edge_sample();
        chk("sat_up", 0, int'(temperature_registered[0 +: TW]), MAXT);
        for (int i = 0; i < 10; i++) begin nd[0] = 1'b1; tick(); nd[0] = 1'b0; tick(); end
        edge_sample();
        chk("sat_down", 0, int'(temperature_registered[0 +: TW]), MINT);
        chk("zone1_idle", 1, int'(temperature_registered[TW +: TW]), MINT);

        // Two ups to 20, then both buttons rise together and stay held
        for (int i = 0; i < 2; i++) begin nu[0] = 1'b1; tick(); nu[0] = 1'b0; tick(); end
        nu[0] = 1'b1; nd[0] = 1'b1; ticks(12);
        nu[0] = 1'b0; nd[0] = 1'b0; tick();
        edge_sample();
        chk("simul_press", 0, int'(temperature_registered[0 +: TW]), 20);

        // AUTO table at sp=20
        press_ac(0);
        for (int k = 0; k < 4; k++) begin
            nt[0 +: TW] = TW'(auto_t[k]);
            tick(); tick();
            edge_sample();
            chk("auto_heat", 0, int'(fan_heat[0 +: 8]), auto_h[k]);
            ticks(24);
            edge_sample();
            chk("auto_speed", 0, int'(fan_speed[0 +: 3]), auto_s[k]);
        end
        press_ac(0); press_ac(0); press_ac(0);
        nt[0 +: TW] = TW'(20);
        ticks(3);

        // OFF -> AUTO -> FAST ramp on zone 0
        press_ac(0);
        na[0] = 1'b1; tick();
        na[0] = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            edge_sample();
            if (k == 4)  chk("ramp_k4", 0, int'(fan_speed[0 +: 3]), 0);
            if (k == 5)  chk("ramp_k5", 0, int'(fan_speed[0 +: 3]), 1);
            if (k == 9)  chk("ramp_k9", 0, int'(fan_speed[0 +: 3]), 2);
            if (k == 13) chk("ramp_k13", 0, int'(fan_speed[0 +: 3]), 3);
            if (k == 17) chk("ramp_k17", 0, int'(fan_speed[0 +: 3]), 4);
        end
        press_ac(0);
        na[0] = 1'b1; tick();
        edge_sample();
        chk("off_mode", 0, int'(current_mode[0 +: 2]), 0);
        chk("off_before", 0, int'(fan_speed[0 +: 3]), 4);
        na[0] = 1'b0; tick();
        edge_sample();
        chk("off_after", 0, int'(fan_speed[0 +: 3]), 0);

        // Hold up on zone 1 for 16 cycles
        nu[1] = 1'b1; ticks(16);
        nu[1] = 1'b0; ticks(2);
        edge_sample();
        chk("hold_up", 1, int'(temperature_registered[TW +: TW]), HOLD_SP);

        // Reset in the middle of a ramp
        press_ac(0);
        na[0] = 1'b1; tick();
        na[0] = 1'b0; press_ac(1);
        ticks(8);
        nrst = 1'b0; tick(); #1;
        chk_reset_state("reset_mid");
        ticks(2);
        nrst = 1'b1; ticks(2);

        // Random buttons, temperatures and occasional resets
        for (int i = 0; i < 1500; i++) begin
            for (int z = 0; z < NZ; z++) begin
                if ($urandom_range(0, 5) == 0) nu[z] = ~nu[z];
                if ($urandom_range(0, 5) == 0) nd[z] = ~nd[z];
                if ($urandom_range(0, 4) == 0) na[z] = ~na[z];
                if ($urandom_range(0, 7) == 0) nt[z*TW +: TW] = TW'($urandom_range(5, 50));
            end
            nrst = ($urandom_range(0, 499) != 0);
            tick();
        end
        nrst = 1'b1; nu = '0; nd = '0; na = '0;
        ticks(2);
        edge_sample();
        edge_sample();
        chk("queue_drained", 0, exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
